hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It drives write-enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers:
- load-use stalls
- branch/jump redirects, resolved in MEM
- external whole-pipeline holds, e.g. a multi-cycle data memory

It also keeps saturating performance counters and a hold-timeout watchdog. It sits beside the pipeline registers in the top-level datapath.

Parameters:
CNT_W, 32, width of each performance counter
HOLD_LIMIT, 16, consecutive ext_stall cycles tolerated before hold_timeout sets (must be at least 1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous reset, active-low
id_rs  in  5  rs field of instruction in IF/ID
id_rt  in  5  rt field of instruction in IF/ID
ex_MemRead  in  1  MemRead currently held in ID/EX
ex_rt  in  5  rt (load destination) currently held in ID/EX
mem_Branch  in  1  Branch held in EX/MEM
mem_Bne  in  1  Bne held in EX/MEM
mem_Jump  in  1  Jump held in EX/MEM
mem_Zero  in  1  ALU zero flag held in EX/MEM
ext_stall  in  1  external hold request
cnt_clear  in  1  synchronous clear of counters and hold_timeout
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_flush  out  1  ID/EX loads all-zero control (bubble)
ex_mem_flush  out  1  EX/MEM loads all-zero control
ex_mem_write  out  1  EX/MEM, MEM/WB load enable
pc_redirect  out  1  PC mux selects branch/jump target
stall_cnt  out  CNT_W  load-use bubbles inserted
flush_cnt  out  CNT_W  redirects taken
hold_cnt  out  CNT_W  ext_stall cycles
hold_timeout  out  1  sticky watchdog flag

Behaviour:
- Definitions:
  - taken = mem_Jump | (mem_Branch & mem_Zero) | (mem_Bne & ~mem_Zero).
  - load_use = ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- Controls are Mealy, combinational from state and current-cycle inputs. Default (RUN, no event): all enables = 1, all flushes = 0, pc_redirect = 0.
- While rst_n = 0, asynchronously:
  - pc_write = if_id_write = ex_mem_write = 0
  - if_id_flush = id_ex_flush = ex_mem_flush = 1
  - pc_redirect = 0
  - state = RUN, counters = 0, hold timer = 0, hold_timeout = 0
- FSM states are RUN, BUBBLE and HOLD. Priority within a cycle: ext_stall > taken > load_use.
- ext_stall = 1 (any state):
  - All write enables = 0, all flushes = 0, pc_redirect = 0. Every pipeline register freezes, so a pending branch in EX/MEM stays visible and is acted on after release.
  - Next state = HOLD. On the next cycle with ext_stall = 0, re-evaluate as in RUN.
- taken = 1 (ext_stall = 0):
  - pc_redirect = 1, pc_write = 1.
  - if_id_flush = id_ex_flush = ex_mem_flush = 1.
  - load_use is ignored.
  - Next state = RUN.
- load_use = 1 in RUN or HOLD (ext_stall = 0, taken = 0):
  - pc_write = 0, if_id_write = 0, id_ex_flush = 1.
  - Next state = BUBBLE.
- BUBBLE:
  - ID/EX now holds a bubble with MemRead = 0. load_use is not evaluated, so at most one bubble is inserted per load.
  - Defaults apply unless taken or ext_stall.
  - Next state = RUN.
- Counters saturate at all-ones and never wrap:
  - stall_cnt +1 on each cycle with a load_use stall.
  - flush_cnt +1 on each cycle with a taken redirect.
  - hold_cnt +1 on each ext_stall cycle.
- Watchdog:
  - The hold timer counts consecutive ext_stall cycles and resets to 0 on any ext_stall = 0 cycle.
  - When the timer reaches HOLD_LIMIT, hold_timeout sets and stays set until cnt_clear or reset.
  - The watchdog has no effect on control outputs.
- cnt_clear = 1: counters, hold timer and hold_timeout go to 0 at the next edge. Clear wins over a same-cycle increment. FSM and control outputs are unaffected.
- Register 0 is never a load-use hazard: ex_rt = 0 gives no stall.
- Reset mid-stall or mid-hold aborts to RUN immediately. No deferred redirect survives reset.

Test Plan:
- lw $t0 then add $t1,$t0,$t2 (ex_MemRead=1, ex_rt=8, id_rs=8) -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; next cycle defaults; stall_cnt=1.
- beq with mem_Branch=1, mem_Zero=1, plus load_use in the same cycle -> pc_redirect=1, three flushes=1, no stall; flush_cnt=1, stall_cnt=0. Repeat with mem_Bne=1, mem_Zero=1 -> no redirect.
- ext_stall high 3 cycles while mem_Jump=1 -> all enables 0 and pc_redirect=0 for 3 cycles; redirect on the 4th cycle; hold_cnt=3.
- HOLD_LIMIT=4, ext_stall high 4 cycles -> hold_timeout=1 after the 4th edge and stays 1 after release; cnt_clear pulse -> hold_timeout=0 and all counters 0.
- Load with ex_rt=0 matching id_rs=0 -> no stall. stall_cnt preset near all-ones by forcing CNT_W=4 and 17 stalls -> stall_cnt holds at 15.
- Assert rst_n=0 while in BUBBLE/HOLD -> outputs immediately take the reset values and counters read 0; after release the first cycle shows defaults.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline stall/flush/hold sequencing for the 5-stage MIPS core,
//             with saturating performance counters and a hold watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W      = 32,
    parameter int HOLD_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             mem_Branch,
    input  logic             mem_Bne,
    input  logic             mem_Jump,
    input  logic             mem_Zero,
    input  logic             ext_stall,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             ex_mem_write,
    output logic             pc_redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             hold_timeout
);

    localparam int             c_TW     = $clog2(HOLD_LIMIT + 1);
    localparam logic [c_TW-1:0] c_LIMIT  = c_TW'(HOLD_LIMIT);

    localparam logic [1:0] c_RUN    = 2'd0;
    localparam logic [1:0] c_BUBBLE = 2'd1;
    localparam logic [1:0] c_HOLD   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [c_TW-1:0]  hold_tmr_q, hold_tmr_d;
    logic             hold_timeout_q, hold_timeout_d;

    logic w_taken;
    logic w_load_use;
    logic w_redirect;
    logic w_lu_stall;
    logic w_pc_write, w_if_id_write, w_if_id_flush, w_id_ex_flush;
    logic w_ex_mem_flush, w_ex_mem_write, w_pc_redirect;

    assign w_taken    = mem_Jump | (mem_Branch & mem_Zero) | (mem_Bne & ~mem_Zero);
    assign w_load_use = ex_MemRead & (ex_rt != 5'd0) &
                        ((ex_rt == id_rs) | (ex_rt == id_rt));

    // The bubble already sitting in ID/EX clears MemRead, so BUBBLE skips the check.
    assign w_redirect = ~ext_stall & w_taken;
    assign w_lu_stall = ~ext_stall & ~w_taken & w_load_use & (state_q != c_BUBBLE);

    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_ex_mem_write = 1'b1;
        w_pc_redirect  = 1'b0;
        state_d        = c_RUN;
        if (ext_stall) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            state_d        = c_HOLD;
        end else if (w_redirect) begin
            w_pc_redirect  = 1'b1;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
        end else if (w_lu_stall) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_flush  = 1'b1;
            state_d        = c_BUBBLE;
        end
    end

    // Reset overrides the Mealy outputs without waiting for a clock edge.
    assign pc_write     = rst_n & w_pc_write;
    assign if_id_write  = rst_n & w_if_id_write;
    assign ex_mem_write = rst_n & w_ex_mem_write;
    assign if_id_flush  = ~rst_n | w_if_id_flush;
    assign id_ex_flush  = ~rst_n | w_id_ex_flush;
    assign ex_mem_flush = ~rst_n | w_ex_mem_flush;
    assign pc_redirect  = rst_n & w_pc_redirect;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        hold_cnt_d     = hold_cnt_q;
        hold_tmr_d     = '0;
        hold_timeout_d = hold_timeout_q;
        if (w_lu_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (w_redirect && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
        if (ext_stall  && !(&hold_cnt_q))  hold_cnt_d  = hold_cnt_q + 1'b1;
        if (ext_stall) begin
            hold_tmr_d = (hold_tmr_q >= c_LIMIT) ? c_LIMIT : hold_tmr_q + 1'b1;
            if (hold_tmr_d >= c_LIMIT) hold_timeout_d = 1'b1;
        end
        if (cnt_clear) begin
            stall_cnt_d    = '0;
            flush_cnt_d    = '0;
            hold_cnt_d     = '0;
            hold_tmr_d     = '0;
            hold_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= c_RUN;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            hold_cnt_q     <= '0;
            hold_tmr_q     <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            hold_tmr_q     <= hold_tmr_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign hold_cnt     = hold_cnt_q;
    assign hold_timeout = hold_timeout_q;

endmodule
`default_nettype wire
